// File: rtl/chip8_fb_dualbuf.sv
// ---------------------------------------------------------------------------
// chip8_fb_dualbuf
//   Double-buffered monochrome framebuffer. The CPU draws into a back buffer.
//   A copy engine streams the back buffer into the front buffer once CPU
//   writes have been quiet for REFRESH_HOLD cycles, or once a dirty back
//   buffer has waited MAX_STALE cycles. The VGA side only ever sees the front
//   buffer, so half-drawn sprites are not displayed.
//
//   Ports
//     clk, reset            system clock, synchronous active-high reset
//     fb_addr_x/y           CPU pixel address, word address = {y, x}
//     fb_writedata, fb_WE   CPU pixel write, one pixel per cycle
//     fb_readdata           back-buffer pixel, registered (1-cycle latency)
//     vga_addr_x/y          VGA pixel address
//     vga_pixel             front-buffer pixel, registered (1-cycle latency)
//     copy_busy             high while the copy engine is running
//     frame_done            1-cycle pulse after the last word has been copied
//
//   Optional feature, macro CHIP8_FB_XOR_EN:
//     adds fb_xor (XOR-draw the pixel into the back buffer) and fb_collision
//     (registered old & new for each XOR write, 0 otherwise).
//
//   Rows with y >= FB_HEIGHT are outside the buffer: writes are dropped and
//   reads return 0 on both ports.
// ---------------------------------------------------------------------------
module chip8_fb_dualbuf #(
    parameter int X_BITS       = 6,
    parameter int Y_BITS       = 5,
    parameter int FB_HEIGHT    = 32,
    parameter int REFRESH_HOLD = 1024,
    parameter int MAX_STALE    = 833333
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [X_BITS-1:0] fb_addr_x,
    input  logic [Y_BITS-1:0] fb_addr_y,
    input  logic              fb_writedata,
    input  logic              fb_WE,
    output logic              fb_readdata,
    input  logic [X_BITS-1:0] vga_addr_x,
    input  logic [Y_BITS-1:0] vga_addr_y,
    output logic              vga_pixel,
    output logic              copy_busy,
    output logic              frame_done
`ifdef CHIP8_FB_XOR_EN
    ,
    input  logic              fb_xor,
    output logic              fb_collision
`endif
);

    localparam int unsigned FB_WIDTH = 1 << X_BITS;
    localparam int unsigned DEPTH    = FB_HEIGHT * FB_WIDTH;
    localparam int unsigned IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PW       = $clog2(DEPTH + 1);
    localparam int unsigned HW       = (REFRESH_HOLD > 0) ? $clog2(REFRESH_HOLD + 1) : 1;
    localparam int unsigned SW       = (MAX_STALE > 0) ? $clog2(MAX_STALE + 1) : 1;

    localparam logic [PW-1:0]     PTR_END   = PW'(DEPTH);
    localparam logic [HW-1:0]     HOLD_MAX  = HW'(REFRESH_HOLD);
    localparam logic [SW-1:0]     STALE_MAX = SW'(MAX_STALE);
    localparam logic [Y_BITS:0]   ROWS      = (Y_BITS + 1)'(FB_HEIGHT);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        COPY
    } state_t;

    logic back_mem  [0:DEPTH-1];
    logic front_mem [0:DEPTH-1];

    state_t        state;
    logic          dirty;
    logic [HW-1:0] hold_cnt;
    logic [SW-1:0] stale_cnt;
    logic [PW-1:0] ptr;
    logic          cp_vld;
    logic [IW-1:0] cp_idx;
    logic          cp_data;

    logic [IW-1:0] cpu_idx;
    logic [IW-1:0] vga_idx;
    logic          cpu_in;
    logic          vga_in;
    logic          wr_ok;
    logic          wr_val;
    logic          copy_start;

    // In-range rows always map below DEPTH, so the low IW address bits suffice.
    assign cpu_idx = IW'({fb_addr_y, fb_addr_x});
    assign vga_idx = IW'({vga_addr_y, vga_addr_x});
    assign cpu_in  = ({1'b0, fb_addr_y}  < ROWS);
    assign vga_in  = ({1'b0, vga_addr_y} < ROWS);
    assign wr_ok   = fb_WE & cpu_in;

    always_comb begin
        wr_val = fb_writedata;
`ifdef CHIP8_FB_XOR_EN
        if (fb_xor)
            wr_val = back_mem[cpu_idx] ^ fb_writedata;
`endif
    end

    // A write in the same cycle suppresses the quiet-time trigger but never
    // the staleness trigger, so continuous drawing cannot starve the display.
    always_comb begin
        copy_start = 1'b0;
        if (state == HOLD)
            copy_start = ((hold_cnt >= HOLD_MAX) && !wr_ok) || (stale_cnt >= STALE_MAX);
    end

    // Memories carry no reset so their contents survive it. The front write
    // is gated by reset so a reset abandons the copy on that very edge.
    always_ff @(posedge clk) begin
        if (wr_ok)
            back_mem[cpu_idx] <= wr_val;
        if (cp_vld && !reset)
            front_mem[cp_idx] <= cp_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            dirty        <= 1'b0;
            hold_cnt     <= '0;
            stale_cnt    <= '0;
            ptr          <= '0;
            cp_vld       <= 1'b0;
            cp_idx       <= '0;
            cp_data      <= 1'b0;
            fb_readdata  <= 1'b0;
            vga_pixel    <= 1'b0;
            copy_busy    <= 1'b0;
            frame_done   <= 1'b0;
`ifdef CHIP8_FB_XOR_EN
            fb_collision <= 1'b0;
`endif
        end else begin
            fb_readdata <= cpu_in ? back_mem[cpu_idx] : 1'b0;
            vga_pixel   <= vga_in ? front_mem[vga_idx] : 1'b0;
`ifdef CHIP8_FB_XOR_EN
            fb_collision <= wr_ok && fb_xor && back_mem[cpu_idx] && fb_writedata;
`endif
            frame_done <= 1'b0;

            if (wr_ok)
                hold_cnt <= '0;
            else if (hold_cnt != HOLD_MAX)
                hold_cnt <= hold_cnt + HW'(1);

            // A write landing on the start edge re-marks the buffer dirty.
            if (copy_start) begin
                dirty     <= wr_ok;
                stale_cnt <= '0;
            end else begin
                if (wr_ok)
                    dirty <= 1'b1;
                if (dirty && (stale_cnt != STALE_MAX))
                    stale_cnt <= stale_cnt + SW'(1);
            end

            case (state)
                IDLE: begin
                    cp_vld <= 1'b0;
                    if (dirty)
                        state <= HOLD;
                end
                HOLD: begin
                    cp_vld <= 1'b0;
                    if (copy_start) begin
                        state     <= COPY;
                        copy_busy <= 1'b1;
                        ptr       <= '0;
                    end
                end
                COPY: begin
                    // Read back[ptr] now, write front one cycle later; the
                    // extra cycle at ptr == DEPTH drains the last word.
                    if (ptr != PTR_END) begin
                        cp_data <= back_mem[ptr[IW-1:0]];
                        cp_idx  <= ptr[IW-1:0];
                        cp_vld  <= 1'b1;
                        ptr     <= ptr + PW'(1);
                    end else begin
                        cp_vld     <= 1'b0;
                        state      <= IDLE;
                        copy_busy  <= 1'b0;
                        frame_done <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cp_vld    <= 1'b0;
                    copy_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chip8_fb_dualbuf.sv
module tb_chip8_fb_dualbuf;

    localparam int X_BITS    = 6;
    localparam int Y_BITS    = 6;
    localparam int FB_HEIGHT = 32;
    localparam int RH        = 64;
    localparam int MS        = 600;
    localparam int DEPTH     = FB_HEIGHT << X_BITS;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [X_BITS-1:0] fb_addr_x = '0;
    logic [Y_BITS-1:0] fb_addr_y = '0;
    logic              fb_writedata = 1'b0;
    logic              fb_WE = 1'b0;
    logic              fb_readdata;
    logic [X_BITS-1:0] vga_addr_x = '0;
    logic [Y_BITS-1:0] vga_addr_y = '0;
    logic              vga_pixel;
    logic              copy_busy;
    logic              frame_done;
`ifdef CHIP8_FB_XOR_EN
    logic              fb_xor = 1'b0;
    logic              fb_collision;
`endif

    chip8_fb_dualbuf #(
        .X_BITS(X_BITS),
        .Y_BITS(Y_BITS),
        .FB_HEIGHT(FB_HEIGHT),
        .REFRESH_HOLD(RH),
        .MAX_STALE(MS)
    ) dut (
        .clk(clk),
        .reset(reset),
        .fb_addr_x(fb_addr_x),
        .fb_addr_y(fb_addr_y),
        .fb_writedata(fb_writedata),
        .fb_WE(fb_WE),
        .fb_readdata(fb_readdata),
        .vga_addr_x(vga_addr_x),
        .vga_addr_y(vga_addr_y),
        .vga_pixel(vga_pixel),
        .copy_busy(copy_busy),
        .frame_done(frame_done)
`ifdef CHIP8_FB_XOR_EN
        ,
        .fb_xor(fb_xor),
        .fb_collision(fb_collision)
`endif
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        string tag;
        logic  exp;
    } exp_t;

    exp_t cpu_q[$];
    exp_t vga_q[$];

    bit back_m  [DEPTH];
    bit front_m [DEPTH];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_write(input int x, input int y, input bit v);
        fb_addr_x    = X_BITS'(x);
        fb_addr_y    = Y_BITS'(y);
        fb_writedata = v;
        fb_WE        = 1'b1;
        if (y < FB_HEIGHT)
            back_m[(y << X_BITS) + x] = v;
    endtask

    task automatic cpu_write(input int a, input bit v);
        set_write(a % (1 << X_BITS), a >> X_BITS, v);
        step();
        fb_WE = 1'b0;
    endtask

    task automatic cpu_read(input int x, input int y, input logic exp, input string tag);
        exp_t e;
        fb_addr_x = X_BITS'(x);
        fb_addr_y = Y_BITS'(y);
        e.tag = tag;
        e.exp = exp;
        cpu_q.push_back(e);
        step();
        e = cpu_q.pop_front();
        chk(e.tag, fb_readdata, e.exp);
    endtask

    task automatic vga_read(input int x, input int y, input logic exp, input string tag);
        exp_t e;
        vga_addr_x = X_BITS'(x);
        vga_addr_y = Y_BITS'(y);
        e.tag = tag;
        e.exp = exp;
        vga_q.push_back(e);
        step();
        e = vga_q.pop_front();
        chk(e.tag, vga_pixel, e.exp);
    endtask

    task automatic vga_read_a(input int a, input string tag);
        vga_read(a % (1 << X_BITS), a >> X_BITS, front_m[a], tag);
    endtask

    // Returns once copy_busy has stayed low for long enough that no copy can
    // still be pending (a pending one would start within RH+1 cycles).
    task automatic wait_quiet(input string tag);
        int idle = 0;
        int i = 0;
        while (i < 30000 && idle < RH + 20) begin
            step();
            i++;
            idle = copy_busy ? 0 : idle + 1;
        end
        chk_int(tag, idle, RH + 20);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  first_busy;
        int  n;
        int  cnt;
        bit  v;
        bit  seen;
        bit  nv1920;

        // Reset
        step();
        step();
        chk("reset_copy_busy",   copy_busy,   1'b0);
        chk("reset_frame_done",  frame_done,  1'b0);
        chk("reset_fb_readdata", fb_readdata, 1'b0);
        chk("reset_vga_pixel",   vga_pixel,   1'b0);
        reset = 1'b0;

        // Fill the whole back buffer with back-to-back writes; the staleness
        // trigger must fire MAX_STALE+1 edges after the first write.
        first_busy = -1;
        for (int a = 0; a < DEPTH; a++) begin
            v = (a == 131 || a == 330) ? 1'b0 : 1'($urandom_range(0, 1));
            cpu_write(a, v);
            if (copy_busy && first_busy < 0)
                first_busy = a;
        end
        chk_int("stale_trigger_cycle", first_busy, MS + 1);
        wait_quiet("quiet_after_fill");
        for (int a = 0; a < DEPTH; a++)
            front_m[a] = back_m[a];

        for (int a = 0; a < DEPTH; a += 97)
            vga_read_a(a, "fill_front");
        vga_read_a(DEPTH - 1, "fill_front_last");
        cpu_read(5, 0, back_m[5], "fill_back_5");
        cpu_read(63, 31, back_m[DEPTH - 1], "fill_back_last");

        // Quiet-time trigger and copy length; writes injected mid-copy.
        cpu_write(131, 1'b1);
        n = 0;
        while (!copy_busy && n < 5000) begin
            step();
            n++;
        end
        chk_int("hold_to_copy", n, RH + 1);

        nv1920 = ~back_m[1920];
        cnt = 1;
        while (cnt < 20000) begin
            if (cnt == 400)
                set_write(10, 5, 1'b1);        // addr 330, already read
            else if (cnt == 401)
                set_write(0, 30, nv1920);      // addr 1920, not yet read
            else
                fb_WE = 1'b0;
            step();
            if (!copy_busy)
                break;
            cnt++;
        end
        fb_WE = 1'b0;
        chk_int("copy_length", cnt, DEPTH + 1);
        chk("frame_done_pulse", frame_done, 1'b1);
        for (int a = 0; a < DEPTH; a++)
            front_m[a] = back_m[a];
        front_m[330] = 1'b0;

        vga_read_a(131, "front_3_2_new");
        chk("frame_done_single", frame_done, 1'b0);
        vga_read_a(330, "front_10_5_old");
        vga_read_a(1920, "front_0_30_new");

        seen = 1'b0;
        for (int i = 0; i < 5000 && !seen; i++) begin
            step();
            seen = frame_done;
        end
        chk("second_copy_done", seen, 1'b1);
        front_m[330] = 1'b1;
        vga_read_a(330, "front_10_5_after_second");

        // CPU read-after-write on the next cycle
        v = ~back_m[77];
        cpu_write(77, v);
        cpu_read(13, 1, v, "raw_next_cycle");
        wait_quiet("quiet_after_raw");
        for (int a = 0; a < DEPTH; a++)
            front_m[a] = back_m[a];

        // Out-of-range row: ignored write, zero reads, no copy
        set_write(0, 40, 1'b1);
        step();
        fb_WE = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < RH + 20; i++) begin
            step();
            if (copy_busy)
                seen = 1'b1;
        end
        chk("oor_no_copy", seen, 1'b0);
        cpu_read(0, 40, 1'b0, "oor_cpu_read");
        vga_read(0, 40, 1'b0, "oor_vga_read");

        // Reset while the copy pointer is at 500
        cpu_write(100, ~back_m[100]);
        cpu_write(1000, ~back_m[1000]);
        n = 0;
        while (!copy_busy && n < 5000) begin
            step();
            n++;
        end
        chk("mid_copy_started", copy_busy, 1'b1);
        for (int i = 0; i < 500; i++)
            step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_mid_copy_busy", copy_busy, 1'b0);
        chk("rst_mid_copy_done", frame_done, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            step();
            if (frame_done || copy_busy)
                seen = 1'b1;
        end
        chk("rst_no_frame_done", seen, 1'b0);
        front_m[100] = back_m[100];
        vga_read_a(100, "rst_front_copied");
        vga_read_a(1000, "rst_front_not_copied");
        cpu_read(40, 15, back_m[1000], "rst_back_preserved");

`ifdef CHIP8_FB_XOR_EN
        // XOR drawing and collision flag
        fb_xor = 1'b0;
        set_write(0, 0, 1'b0);
        step();
        chk("xor_plain_collision", fb_collision, 1'b0);
        fb_xor = 1'b1;
        set_write(0, 0, 1'b1);
        step();
        fb_WE = 1'b0;
        chk("xor_first_collision", fb_collision, 1'b0);
        cpu_read(0, 0, 1'b1, "xor_first_stored");
        set_write(0, 0, 1'b1);
        step();
        fb_WE = 1'b0;
        chk("xor_second_collision", fb_collision, 1'b1);
        fb_xor = 1'b0;
        cpu_read(0, 0, 1'b0, "xor_second_stored");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
